// File: rtl/kl10_cram_pkg.sv
// Shared CRAM sequencer definitions.
//   ADR_W      CRAM address width
//   SBR_DEPTH  default subroutine stack depth
//   ADR_1777   forced trap address
//   sbr_cmd_e  decoded subroutine-stack command for one cycle
package kl10_cram_pkg;

  localparam int unsigned ADR_W     = 11;
  localparam int unsigned SBR_DEPTH = 16;
  localparam logic [ADR_W-1:0] ADR_1777 = 11'o1777;

  typedef enum logic [2:0] {
    SBR_HOLD,
    SBR_CLEAR,
    SBR_PUSH,
    SBR_POP,
    SBR_REPLACE
  } sbr_cmd_e;

endpackage

// File: rtl/sbr_stack_ptr.sv
// Stack pointer, entry count and sticky flags for the microcode subroutine stack.
// Ports:
//   clk, reset             clock, async active-high reset
//   adv                    microword executes this cycle
//   call, ret, force1777   raw CALL / RETURN / trap controls
//   diagClear              diagnostic clear (independent of adv)
//   sp                     current next-free-slot index
//   sp_next                post-update index (for top-of-stack lookahead)
//   depthCnt               valid entries, 0..DEPTH
//   overflow, underflow    sticky flags
//   wr_en, wr_idx          memory write strobe and slot for this cycle
module sbr_stack_ptr
  import kl10_cram_pkg::*;
#(
  parameter int unsigned DEPTH = SBR_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic             call,
  input  logic             ret,
  input  logic             force1777,
  input  logic             diagClear,
  output logic [PTR_W-1:0] sp,
  output logic [PTR_W-1:0] sp_next,
  output logic [5:0]       depthCnt,
  output logic             overflow,
  output logic             underflow,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_idx
);

  localparam logic [5:0] FULL = 6'(DEPTH);

  sbr_cmd_e   cmd;
  logic       push;
  logic       pop;
  logic [5:0] depth_next;
  logic       ovf_next;
  logic       udf_next;

  // Trap to 1777 is a CALL and masks a coincident RETURN.
  assign push = adv & (call | force1777);
  assign pop  = adv & ret & ~force1777;

  always_comb begin
    cmd = SBR_HOLD;
    if (diagClear)
      cmd = SBR_CLEAR;
    else if (push && pop && depthCnt != '0)
      cmd = SBR_REPLACE;
    else if (push)
      cmd = SBR_PUSH;
    else if (pop)
      cmd = SBR_POP;
  end

  always_comb begin
    sp_next    = sp;
    depth_next = depthCnt;
    ovf_next   = overflow;
    udf_next   = underflow;
    wr_en      = 1'b0;
    wr_idx     = sp;
    unique case (cmd)
      SBR_CLEAR: begin
        sp_next    = '0;
        depth_next = '0;
        ovf_next   = 1'b0;
        udf_next   = 1'b0;
      end
      SBR_REPLACE: begin
        wr_en  = 1'b1;
        wr_idx = sp - 1'b1;
      end
      SBR_PUSH: begin
        wr_en   = 1'b1;
        sp_next = sp + 1'b1;
        if (depthCnt == FULL)
          ovf_next = 1'b1;
        else
          depth_next = depthCnt + 1'b1;
      end
      SBR_POP: begin
        sp_next = sp - 1'b1;
        if (depthCnt == '0)
          udf_next = 1'b1;
        else
          depth_next = depthCnt - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp        <= '0;
      depthCnt  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_next;
      depthCnt  <= depth_next;
      overflow  <= ovf_next;
      underflow <= udf_next;
    end
  end

endmodule

// File: rtl/cram_sbr_stack.sv
// Microcode subroutine CALL/RETURN stack for the CRAM address sequencer.
// Ports:
//   clk, reset     clock, async active-high reset
//   adv            microword executes; 0 freezes all but diagClear
//   call, ret      CALL bit / RETURN dispatch
//   force1777      forced trap, behaves as CALL and masks ret
//   pushAdr        return address to save
//   diagClear      diagnostic clear of pointer, count, flags, sbrRet
//   sbrRet         registered top-of-stack entry
//   stackAdr       zero-extended stack pointer for EBUS readback
//   depthCnt       number of valid entries
//   overflow       sticky: push while full
//   underflow      sticky: pop while empty
module cram_sbr_stack
  import kl10_cram_pkg::*;
#(
  parameter int unsigned DEPTH = SBR_DEPTH,
  parameter int unsigned ADR_W = kl10_cram_pkg::ADR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic             call,
  input  logic             ret,
  input  logic             force1777,
  input  logic [0:ADR_W-1] pushAdr,
  input  logic             diagClear,
  output logic [0:ADR_W-1] sbrRet,
  output logic [0:4]       stackAdr,
  output logic [0:5]       depthCnt,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [0:ADR_W-1] mem [DEPTH];
  logic [PTR_W-1:0] sp;
  logic [PTR_W-1:0] sp_next;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic             wr_en;
  logic [5:0]       depth;
  logic [0:ADR_W-1] ret_next;

  sbr_stack_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr (
    .clk       (clk),
    .reset     (reset),
    .adv       (adv),
    .call      (call),
    .ret       (ret),
    .force1777 (force1777),
    .diagClear (diagClear),
    .sp        (sp),
    .sp_next   (sp_next),
    .depthCnt  (depth),
    .overflow  (overflow),
    .underflow (underflow),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx)
  );

  assign depthCnt = depth;
  assign stackAdr = 5'(sp);

  // sbrRet must hold the post-update top on the same edge that writes memory,
  // so read at sp_next-1 and bypass the entry being written this cycle.
  always_comb begin
    rd_idx   = sp_next - 1'b1;
    ret_next = mem[rd_idx];
    if (wr_en && wr_idx == rd_idx)
      ret_next = pushAdr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= pushAdr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sbrRet <= '0;
    else if (diagClear)
      sbrRet <= '0;
    else if (adv)
      sbrRet <= ret_next;
  end

endmodule

// File: tb/tb_cram_sbr_stack.sv
module tb_cram_sbr_stack;

  localparam int D = 16;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          adv, call, ret, force1777, diagClear;
  logic [0:AW-1] pushAdr;
  logic [0:AW-1] sbrRet;
  logic [0:4]    stackAdr;
  logic [0:5]    depthCnt;
  logic          overflow, underflow;

  cram_sbr_stack #(.DEPTH(D), .ADR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .adv       (adv),
    .call      (call),
    .ret       (ret),
    .force1777 (force1777),
    .pushAdr   (pushAdr),
    .diagClear (diagClear),
    .sbrRet    (sbrRet),
    .stackAdr  (stackAdr),
    .depthCnt  (depthCnt),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  typedef struct {
    string       tag;
    logic [10:0] r;
    logic [4:0]  sa;
    logic [5:0]  dc;
    logic        ov;
    logic        uf;
  } exp_t;

  exp_t sb[$];

  // Reference model of the stack as described for the sequencer.
  logic [10:0] m_mem [D];
  int          m_sp, m_dc;
  logic        m_ov, m_uf;
  logic [10:0] m_ret;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0o expected=%0o", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_sp = 0; m_dc = 0; m_ov = 0; m_uf = 0; m_ret = '0;
  endtask

  task automatic compare_all(input exp_t e);
    check({e.tag, ".sbrRet"},    32'(sbrRet),    32'(e.r));
    check({e.tag, ".stackAdr"},  32'(stackAdr),  32'(e.sa));
    check({e.tag, ".depthCnt"},  32'(depthCnt),  32'(e.dc));
    check({e.tag, ".overflow"},  32'(overflow),  32'(e.ov));
    check({e.tag, ".underflow"}, 32'(underflow), 32'(e.uf));
  endtask

  // Drive one cycle, predict its outcome, then compare after the edge.
  task automatic step(input bit a, input bit c, input bit r, input bit f,
                      input bit clr, input logic [10:0] adr, input string tag);
    bit   psh, pp;
    exp_t e;
    adv = a; call = c; ret = r; force1777 = f; diagClear = clr; pushAdr = adr;
    if (clr) begin
      m_sp = 0; m_dc = 0; m_ov = 0; m_uf = 0; m_ret = '0;
    end else if (a) begin
      psh = c | f;
      pp  = r & ~f;
      if (psh && pp && m_dc > 0) begin
        m_mem[(m_sp + D - 1) % D] = adr;
      end else if (psh) begin
        m_mem[m_sp] = adr;
        m_sp = (m_sp + 1) % D;
        if (m_dc == D) m_ov = 1; else m_dc++;
      end else if (pp) begin
        m_sp = (m_sp + D - 1) % D;
        if (m_dc == 0) m_uf = 1; else m_dc--;
      end
      m_ret = m_mem[(m_sp + D - 1) % D];
    end
    e.tag = tag; e.r = m_ret; e.sa = 5'(m_sp); e.dc = 6'(m_dc); e.ov = m_ov; e.uf = m_uf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compare_all(e);
  endtask

  initial begin
    exp_t e0;
    reset = 1'b1; adv = 0; call = 0; ret = 0; force1777 = 0; diagClear = 0; pushAdr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    e0.tag = "reset"; e0.r = '0; e0.sa = '0; e0.dc = '0; e0.ov = 0; e0.uf = 0;
    compare_all(e0);
    reset = 1'b0;

    // First CALL
    step(1, 1, 0, 0, 0, 11'o0123, "call1");
    check("call1.direct_ret", 32'(sbrRet), 32'o0123);
    check("call1.direct_sa", 32'(stackAdr), 32'd1);

    // Push 1..3, then three returns
    step(1, 0, 0, 0, 1, 11'o0, "clr_a");
    for (int i = 1; i <= 3; i++) step(1, 1, 0, 0, 0, 11'(i), "push3");
    step(1, 0, 1, 0, 0, 11'o0, "ret1");
    check("ret1.direct", 32'(sbrRet), 32'o0002);
    step(1, 0, 1, 0, 0, 11'o0, "ret2");
    check("ret2.direct", 32'(sbrRet), 32'o0001);
    step(1, 0, 1, 0, 0, 11'o0, "ret3");
    check("ret3.dc", 32'(depthCnt), 32'd0);
    check("ret3.uf", 32'(underflow), 32'd0);

    // Forced trap overrides a coincident return
    step(1, 0, 1, 1, 0, 11'o0456, "f1777");
    check("f1777.direct", 32'(sbrRet), 32'o0456);

    // Replace top with call+ret at depth 2
    step(1, 0, 0, 0, 1, 11'o0, "clr_b");
    step(1, 1, 0, 0, 0, 11'o0050, "rp_push1");
    step(1, 1, 0, 0, 0, 11'o0100, "rp_push2");
    step(1, 1, 1, 0, 0, 11'o0200, "replace");
    check("replace.direct_dc", 32'(depthCnt), 32'd2);
    check("replace.direct_sa", 32'(stackAdr), 32'd2);
    step(1, 0, 1, 0, 0, 11'o0, "rp_pop");
    check("rp_pop.direct", 32'(sbrRet), 32'o0050);

    // call+ret on an empty stack is a plain push without underflow
    step(1, 0, 0, 0, 1, 11'o0, "clr_c");
    step(1, 1, 1, 0, 0, 11'o0321, "cr_empty");

    // Overflow then underflow
    step(1, 0, 0, 0, 1, 11'o0, "clr_d");
    for (int i = 1; i <= 17; i++) step(1, 1, 0, 0, 0, 11'(i), "ovf_push");
    check("ovf.direct_ov", 32'(overflow), 32'd1);
    check("ovf.direct_dc", 32'(depthCnt), 32'd16);
    check("ovf.direct_ret", 32'(sbrRet), 32'd17);
    for (int i = 0; i < 16; i++) step(1, 0, 1, 0, 0, 11'o0, "ovf_pop");
    check("drain.direct_uf", 32'(underflow), 32'd0);
    step(1, 0, 1, 0, 0, 11'o0, "udf_pop");
    check("udf.direct_uf", 32'(underflow), 32'd1);

    // Build depth 5 with both flags still set, freeze, then clear while frozen
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 11'(12'o0700 + i), "d5_push");
    step(0, 1, 1, 0, 0, 11'o0777, "frozen");
    step(0, 0, 1, 1, 0, 11'o0666, "frozen2");
    step(0, 1, 0, 0, 1, 11'o0555, "diag_clr");
    check("diag_clr.direct_sa", 32'(stackAdr), 32'd0);
    check("diag_clr.direct_ret", 32'(sbrRet), 32'd0);
    step(0, 0, 0, 0, 0, 11'o0, "post_clr_hold");

    // Back-to-back call/return with no bubble
    step(1, 1, 0, 0, 0, 11'o1111, "b2b_call");
    step(1, 0, 1, 0, 0, 11'o0, "b2b_ret");
    step(1, 1, 0, 0, 0, 11'o1234, "b2b_call2");
    step(1, 1, 0, 0, 0, 11'o1235, "b2b_call3");

    // Asynchronous reset between edges
    #2 reset = 1'b1;
    #1;
    model_reset();
    e0.tag = "async_rst"; e0.r = '0; e0.sa = '0; e0.dc = '0; e0.ov = 0; e0.uf = 0;
    compare_all(e0);
    #1 reset = 1'b0;
    step(1, 1, 0, 0, 0, 11'o1777, "after_rst");
    check("after_rst.direct", 32'(sbrRet), 32'o1777);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/cram_sbr_stack.md
# cram_sbr_stack

Microcode subroutine CALL/RETURN stack for the CRAM address sequencer. It saves the 11-bit return address on every microcode CALL or forced trap to 1777, and presents the top entry as `sbrRet` for the RETURN dispatch into CRADR. It also maintains the stack pointer, sticky overflow/underflow flags, and the diagnostic clear and readback path used over EBUS diagnostic functions.

## Interface
Parameters:
- `DEPTH`, 16: number of stack entries; must be a power of two (2..32).
- `ADR_W`, 11: CRAM address width.

Ports:
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `adv` in 1: a microword executes this cycle; when 0, all state holds.
- `call` in 1: CRAM CALL bit of the executing microword.
- `ret` in 1: RETURN dispatch decoded (DISP 00-03 with DISP[3:4]=11).
- `force1777` in 1: forced trap to 1777, treated as a CALL.
- `pushAdr` in [0:ADR_W-1]: return address to save (current CRAM location).
- `diagClear` in 1: diagnostic stack clear, from the decoded diagnostic function strobe.
- `sbrRet` out [0:ADR_W-1]: top-of-stack entry, registered.
- `stackAdr` out [0:4]: zero-extended stack pointer, used for diagnostic EBUS readback.
- `depthCnt` out [0:5]: number of valid entries, 0..DEPTH.
- `overflow` out 1: sticky flag; a push occurred while full.
- `underflow` out 1: sticky flag; a pop occurred while empty.

## Operation
- Storage is `DEPTH` x `ADR_W` registers.
  - `sp` is the index of the next free slot; the top of stack is `mem[sp-1]`, computed modulo `DEPTH`.
- Effective controls, evaluated only when `adv`=1:
  - `push = call | force1777`
  - `pop = ret & ~force1777`
  - `force1777` suppresses `ret`.
- Command priority (evaluate in this order):
  - `diagClear`: `sp`=0, `depthCnt`=0, `overflow`=0, `underflow`=0, `sbrRet`=0. Memory is untouched. This applies regardless of `adv`.
  - `push & pop`, with `depthCnt`>0: replace the top. `mem[sp-1]`<=`pushAdr`; `sp` and `depthCnt` are unchanged.
  - `push & pop`, with `depthCnt`=0: behaves as a plain push. No underflow is flagged.
  - `push` alone:
    - `mem[sp]`<=`pushAdr`; `sp`<=`sp+1` (wraps).
    - If `depthCnt`=`DEPTH`, set `overflow`=1 and leave the count unchanged; the oldest entry is overwritten. Otherwise increment `depthCnt`.
  - `pop` alone:
    - `sp`<=`sp-1` (wraps).
    - If `depthCnt`=0, set `underflow`=1 and leave the count at 0. Otherwise decrement `depthCnt`.
  - Neither: hold.
- `sbrRet` is loaded each cycle with the post-update `mem[sp-1]`, including write-through of a same-cycle push.
  - An empty stack yields stale contents. This is by design; microcode never returns when empty.
- Reset: `sp`=0, `depthCnt`=0, all memory entries 0, `sbrRet`=0, `stackAdr`=0, `overflow`=0, `underflow`=0.

## Timing
- Push-to-visible latency is 1 cycle: `sbrRet` equals `pushAdr` in the cycle after the push edge.
- After a pop, `sbrRet` shows the new top in the next cycle.
- Back-to-back CALL/RETURN on consecutive cycles is required with no bubbles.
- The CRA consumes `sbrRet` in the same cycle as the RETURN microword. `sbrRet` must therefore already be valid, since it was registered on the preceding edge.
- `adv`=0 freezes everything except `diagClear`.
- Reset asserted mid-sequence clears asynchronously. First operation is possible on the first edge after deassertion.
- Flags stay set until `reset` or `diagClear`.

## Structure
- Shared package `kl10_cram_pkg`: `ADR_W` (11), `SBR_DEPTH` (16), `ADR_1777` (11'o1777).
- One sub-module, `sbr_stack_ptr`: the `sp`/`depthCnt`/flag update logic with push/pop/replace decode.
- Memory and `sbrRet` registering stay in the top module.

## Test plan
- Reset, then `call` with `pushAdr`=0o0123 → next cycle `sbrRet`=0o0123, `stackAdr`=1, `depthCnt`=1.
- Push 0o0001..0o0003, then three `ret` → `sbrRet` sequence 0o0002, 0o0001, then stale; `depthCnt` 2, 1, 0; `underflow`=0.
- `force1777` with `ret`=1, `pushAdr`=0o0456 → treated as a push; `depthCnt`+1, `sbrRet`=0o0456.
- `call` and `ret` together with depth 2 and top 0o0100, `pushAdr`=0o0200 → `sbrRet`=0o0200, `depthCnt`=2, `sp` unchanged.
- 17 pushes of values 1..17 → `overflow`=1, `depthCnt`=16, `sbrRet`=17. After 16 pops, a further pop sets `underflow`=1.
- `diagClear` while `adv`=0 at depth 5 with flags set → next cycle `stackAdr`=0, `depthCnt`=0, flags 0, `sbrRet`=0.
